// File: rtl/fece_seq_divider.sv
// fece_seq_divider: iterative restoring divider, one quotient bit per cycle.
// Undoes the 3x3 exact multiplier: 6-bit product / 3-bit factor -> 6-bit
// quotient plus 3-bit remainder, with a start/busy/done handshake.
module fece_seq_divider #(
    parameter int DIVIDEND_W = 6,
    parameter int DIVISOR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIVIDEND_W-1:0] dvd_sr;
    logic [DIVIDEND_W-1:0] quo_sr;
    logic [DIVIDEND_W-1:0] quo_next;
    logic [DIVISOR_W:0]    partial_rem;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    rem_next;
    logic [DIVISOR_W:0]    divisor_ext;
    logic [DIVISOR_W-1:0]  divisor_reg;
    logic [CNT_W-1:0]      count;
    logic                  accept;
    logic                  ge;
    logic                  last_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The shift discards the partial remainder MSB, which is always zero
    // because the remainder stays below the divisor.
    always_comb begin
        accept      = start && ((state == IDLE) || (state == DONE));
        divisor_ext = {1'b0, divisor_reg};
        trial       = (partial_rem << 1) | (DIVISOR_W + 1)'(dvd_sr[DIVIDEND_W-1]);
        ge          = (trial >= divisor_ext);
        rem_next    = ge ? (trial - divisor_ext) : trial;
        quo_next    = (quo_sr << 1) | DIVIDEND_W'(ge);
        last_step   = (count == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; DONE accepts a new start like IDLE.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration registers and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_sr      <= '0;
            quo_sr      <= '0;
            partial_rem <= '0;
            divisor_reg <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else begin
                dvd_sr      <= dividend;
                quo_sr      <= '0;
                partial_rem <= '0;
                divisor_reg <= divisor;
                count       <= CNT_W'(DIVIDEND_W);
            end
        end else if (state == CALC) begin
            dvd_sr      <= dvd_sr << 1;
            quo_sr      <= quo_next;
            partial_rem <= rem_next;
            count       <= count - CNT_W'(1);
            if (last_step) begin
                quotient    <= quo_next;
                remainder   <= rem_next[DIVISOR_W-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fece_seq_divider.sv
// tb_fece_seq_divider: directed checks of the sequential divider handshake,
// arithmetic boundaries, dropped starts, reset abort and a full operand sweep.
module tb_fece_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       div_by_zero;

    int errors;
    int checks;
    int cyc;
    logic saw_busy;
    logic saw_done;

    fece_seq_divider #(
        .DIVIDEND_W(6),
        .DIVISOR_W (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next falling edge and note what the handshake shows.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (busy === 1'b1) saw_busy = 1'b1;
        if (done === 1'b1) saw_done = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present one start request for a single clock; cyc counts edges from here.
    task automatic apply_stimulus(input logic [5:0] a, input logic [2:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        cyc      = 0;
        saw_busy = 1'b0;
        saw_done = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 40) tick();
    endtask

    task automatic check_result(input string tag, input int exp_lat, input logic [5:0] eq,
                                input logic [2:0] er, input logic ez);
        wait_done();
        check_output({tag, "_done"}, done, 1);
        check_output({tag, "_lat"}, cyc, exp_lat);
        check_output({tag, "_quo"}, quotient, eq);
        check_output({tag, "_rem"}, remainder, er);
        check_output({tag, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        saw_busy = 1'b0;
        saw_done = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (3) tick();
        rst = 1'b0;

        // Idle after reset: everything zero for ten cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("idle_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
        end

        // Exact divisions and single-cycle done pulse.
        apply_stimulus(6'd35, 3'd5);
        check_output("35_5_busy", busy, 1);
        check_result("35_5", 7, 6'd7, 3'd0, 1'b0);
        tick();
        check_output("35_5_pulse", done, 0);
        check_output("35_5_hold", quotient, 7);

        apply_stimulus(6'd49, 3'd7);
        check_result("49_7", 7, 6'd7, 3'd0, 1'b0);
        tick();

        // Boundaries: divisor 1 with max dividend, divisor larger, remainder.
        apply_stimulus(6'd63, 3'd1);
        check_result("63_1", 7, 6'd63, 3'd0, 1'b0);
        tick();
        apply_stimulus(6'd5, 3'd7);
        check_result("5_7", 7, 6'd0, 3'd5, 1'b0);
        tick();
        apply_stimulus(6'd62, 3'd4);
        check_result("62_4", 7, 6'd15, 3'd2, 1'b0);
        tick();
        apply_stimulus(6'd0, 3'd3);
        check_result("0_3", 7, 6'd0, 3'd0, 1'b0);
        tick();

        // Divide by zero finishes in one cycle without busy.
        apply_stimulus(6'd10, 3'd0);
        check_result("10_0", 1, 6'd63, 3'd0, 1'b1);
        check_output("10_0_nobusy", saw_busy, 0);
        tick();
        check_output("10_0_flag_hold", div_by_zero, 1);
        apply_stimulus(6'd20, 3'd3);
        check_result("20_3", 7, 6'd6, 3'd2, 1'b0);
        tick();

        // Start while busy is dropped; start in DONE runs back to back.
        apply_stimulus(6'd45, 3'd6);
        tick();
        start    = 1'b1;
        dividend = 6'd9;
        divisor  = 3'd3;
        tick();
        start = 1'b0;
        check_output("45_6_still_busy", busy, 1);
        check_result("45_6", 7, 6'd7, 3'd3, 1'b0);
        apply_stimulus(6'd9, 3'd3);
        check_output("b2b_busy", busy, 1);
        check_output("b2b_hold_quo", quotient, 7);
        check_result("9_3", 7, 6'd3, 3'd0, 1'b0);
        tick();

        // Reset on the third CALC cycle abandons the division.
        apply_stimulus(6'd63, 3'd2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (10) tick();
        check_output("abort_no_done", saw_done, 0);
        check_output("abort_no_busy", saw_busy, 0);

        // Every operand pair against the quotient/remainder invariant.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 8; b++) begin
                apply_stimulus(6'(a), 3'(b));
                wait_done();
                check_output("sweep_done", done, 1);
                if (b == 0) begin
                    check_output("sweep_lat0", cyc, 1);
                    check_output("sweep_dbz_quo", quotient, 63);
                    check_output("sweep_dbz_rem", remainder, 0);
                    check_output("sweep_dbz_flag", div_by_zero, 1);
                end else begin
                    check_output("sweep_lat", cyc, 7);
                    check_output("sweep_invariant", int'(quotient) * b + int'(remainder), a);
                    check_output("sweep_rem_lt", (int'(remainder) < b) ? 1 : 0, 1);
                    check_output("sweep_flag", div_by_zero, 0);
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
